// File: rtl/mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx
//
// Memory-mapped 8N1 UART transmitter with a small byte FIFO.
//
//   TXDATA at BASE_ADDR     : a store with we[0] pushes dwdata[7:0]; reads 0.
//   STATUS at BASE_ADDR + 4 : {24'b0, count[3:0], ovf, empty, full, busy}.
//                             A store with we[0] and dwdata[3] clears ovf.
//
// Ports
//   clk        : system clock, all state changes on the rising edge
//   reset      : synchronous, active-high reset
//   daddr      : CPU data address (shared with dmem)
//   dwdata     : CPU store data
//   we         : CPU byte write enables, we[0] covers dwdata[7:0]
//   mmio_sel   : combinational, high when daddr hits either register
//   mmio_rdata : combinational read data for the addressed register
//   tx         : registered serial output, idle high
// -----------------------------------------------------------------------------
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] daddr,
   input  logic [31:0] dwdata,
   input  logic [3:0]  we,
   output logic        mmio_sel,
   output logic [31:0] mmio_rdata,
   output logic        tx
);

   localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;
   localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH);
   // Count must hold FIFO_DEPTH itself (up to 16), so it is one bit wider
   // than the largest pointer.
   localparam int unsigned CNT_W       = 5;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [15:0] BAUD_LOAD   = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t           state;
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic             ovf;
   logic [15:0]      baud;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;

   logic sel_data;
   logic sel_stat;
   logic empty;
   logic full;
   logic busy;
   logic pop;
   logic push_req;
   logic push_ok;
   logic ovf_set;
   logic ovf_clr;

   // Upper store bits and byte enables have no function in this block.
   logic unused_bits;
   assign unused_bits = &{1'b0, dwdata[31:8], we[3:1]};

   // -------------------------------------------------------------------------
   // Decode and FIFO handshake
   // -------------------------------------------------------------------------
   assign sel_data = (daddr == BASE_ADDR);
   assign sel_stat = (daddr == STATUS_ADDR);
   assign mmio_sel = sel_data | sel_stat;

   assign empty = (count == '0);
   assign full  = (count == DEPTH_C);
   assign busy  = (state != IDLE);

   // The FSM takes a byte when it is idle, or at the last cycle of a stop bit
   // so that queued frames go out with no idle gap between them.
   assign pop = !empty && ((state == IDLE) || ((state == STOP) && (baud == '0)));

   assign push_req = sel_data && we[0];
   // A full FIFO still accepts a byte when the head leaves on the same edge.
   assign push_ok  = push_req && (!full || pop);
   assign ovf_set  = push_req && !push_ok;
   assign ovf_clr  = sel_stat && we[0] && dwdata[3];

   // NOTE: every output of an always_comb gets a default first so that no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      mmio_rdata = 32'b0;
      if (sel_stat) begin
         mmio_rdata = {24'b0, count[3:0], ovf, empty, full, busy};
      end
   end

   // -------------------------------------------------------------------------
   // FIFO storage
   // NOTE: the data array is deliberately left out of reset; head, tail and
   // count define which entries are valid, so clearing it buys nothing.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset && push_ok) begin
         mem[tail] <= dwdata[7:0];
      end
   end

   // -------------------------------------------------------------------------
   // FIFO pointers, flags and transmit FSM
   // NOTE: sequential state uses non-blocking assignments only, so every
   // right-hand side below sees the values from before this edge (e.g. the
   // pop reads mem[head] while head advances on the same edge).
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         tx      <= 1'b1;
         count   <= '0;
         head    <= '0;
         tail    <= '0;
         ovf     <= 1'b0;
         baud    <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         if (push_ok) begin
            tail <= tail + PTR_W'(1);
         end
         if (pop) begin
            head <= head + PTR_W'(1);
         end

         unique case ({push_ok, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase

         // A new overflow on this edge takes priority over a software clear.
         if (ovf_set) begin
            ovf <= 1'b1;
         end else if (ovf_clr) begin
            ovf <= 1'b0;
         end

         unique case (state)
            IDLE: begin
               if (pop) begin
                  shift <= mem[head];
                  baud  <= BAUD_LOAD;
                  tx    <= 1'b0;
                  state <= START;
               end
            end

            START: begin
               if (baud == '0) begin
                  baud    <= BAUD_LOAD;
                  bit_idx <= '0;
                  tx      <= shift[0];
                  state   <= DATA;
               end else begin
                  baud <= baud - 16'd1;
               end
            end

            DATA: begin
               if (baud == '0) begin
                  baud <= BAUD_LOAD;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     // shift[0] is the bit on the line now; shift[1] is next.
                     bit_idx <= bit_idx + 3'd1;
                     shift   <= {1'b0, shift[7:1]};
                     tx      <= shift[1];
                  end
               end else begin
                  baud <= baud - 16'd1;
               end
            end

            STOP: begin
               if (baud == '0) begin
                  if (pop) begin
                     shift <= mem[head];
                     baud  <= BAUD_LOAD;
                     tx    <= 1'b0;
                     state <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  baud <= baud - 16'd1;
               end
            end

            default: begin
               state <= IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_mmio_uart_tx
//
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8.
// Register accesses come from a vector table; frame timing, FIFO fill and
// overflow, back-to-back frames and mid-frame reset use hand-written
// sequences. A line monitor decodes every frame seen on tx.
// -----------------------------------------------------------------------------
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE = 32'hFFFF_0000;
   localparam logic [31:0] STAT = 32'hFFFF_0004;
   localparam int          CPB  = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] daddr;
   logic [31:0] dwdata;
   logic [3:0]  we;
   logic        mmio_sel;
   logic [31:0] mmio_rdata;
   logic        tx;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   mmio_uart_tx #(
      .BASE_ADDR    (BASE),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .daddr      (daddr),
      .dwdata     (dwdata),
      .we         (we),
      .mmio_sel   (mmio_sel),
      .mmio_rdata (mmio_rdata),
      .tx         (tx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // --------------------------------------------------------------------------
   // Line monitor: cnt counts cycles of the current frame (1..10*CPB), data
   // and stop bits are sampled at the middle of their bit slots.
   // --------------------------------------------------------------------------
   logic [8:0] rx_q[$];      // {stop_ok, data}
   int         start_q[$];
   int         end_q[$];
   int         mon_cnt = 0;
   int         mon_start = 0;
   logic [7:0] mon_byte;
   logic       mon_stop;

   always @(negedge clk) begin
      if (reset) begin
         mon_cnt = 0;
      end else if (mon_cnt == 0) begin
         if (tx == 1'b0) begin
            mon_cnt   = 1;
            mon_start = cyc;
         end
      end else begin
         mon_cnt++;
         for (int j = 0; j < 8; j++) begin
            if (mon_cnt == (j + 1) * CPB + 2) mon_byte[j] = tx;
         end
         if (mon_cnt == 9 * CPB + 2) mon_stop = tx;
         if (mon_cnt == 10 * CPB) begin
            rx_q.push_back({mon_stop, mon_byte});
            start_q.push_back(mon_start);
            end_q.push_back(cyc);
            mon_cnt = 0;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Helpers
   // --------------------------------------------------------------------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      daddr  = a;
      dwdata = d;
      we     = w;
   endtask

   // Advance past one rising edge; inputs are then safe to change.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected tx k cycles after the push edge; the start bit begins at k=1.
   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k >= 1 && k <= CPB) return 1'b0;
      if (k > CPB && k <= 9 * CPB) return b[(k - CPB - 1) / CPB];
      return 1'b1;
   endfunction

   task automatic wait_idle(input int max_cyc);
      int n;
      n = 0;
      bus(STAT, 32'h0, 4'h0);
      @(negedge clk);
      while ((mmio_rdata[0] !== 1'b0 || mmio_rdata[2] !== 1'b1) && n < max_cyc) begin
         n++;
         @(negedge clk);
      end
      check("wait_idle_in_time", 32'(n < max_cyc), 32'd1);
      step();
   endtask

   task automatic clear_mon();
      rx_q.delete();
      start_q.delete();
      end_q.delete();
   endtask

   // --------------------------------------------------------------------------
   // Register access vectors, applied from the reset state
   // --------------------------------------------------------------------------
   typedef struct {
      logic [31:0] daddr;
      logic [31:0] dwdata;
      logic [3:0]  we;
      logic        exp_sel;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[11];

   initial begin
      int zeros;

      vecs[0]  = '{STAT,          32'h0,  4'b0000, 1'b1, 32'h04};
      vecs[1]  = '{BASE,          32'h0,  4'b0000, 1'b1, 32'h00};
      vecs[2]  = '{BASE + 32'd8,  32'h0,  4'b0000, 1'b0, 32'h00};
      vecs[3]  = '{BASE,          32'hAA, 4'b1110, 1'b1, 32'h00};
      vecs[4]  = '{STAT,          32'h0,  4'b0000, 1'b1, 32'h04};
      vecs[5]  = '{STAT,          32'h55, 4'b0001, 1'b1, 32'h04};
      vecs[6]  = '{STAT,          32'h0,  4'b0000, 1'b1, 32'h04};
      vecs[7]  = '{BASE - 32'd4,  32'h11, 4'b1111, 1'b0, 32'h00};
      vecs[8]  = '{STAT,          32'h0,  4'b0000, 1'b1, 32'h04};
      vecs[9]  = '{32'h0,         32'h22, 4'b1111, 1'b0, 32'h00};
      vecs[10] = '{STAT,          32'h0,  4'b0000, 1'b1, 32'h04};

      // ---- reset state, with a push held on the bus during reset ----------
      reset = 1'b1;
      bus(BASE, 32'h77, 4'b0001);
      repeat (3) step();
      check("reset_tx", 32'(tx), 32'd1);
      bus(STAT, 32'h0, 4'h0);
      @(negedge clk);
      check("reset_sel", 32'(mmio_sel), 32'd1);
      check("reset_status", mmio_rdata, 32'h04);
      step();
      reset = 1'b0;
      step();

      // ---- table-driven register accesses ---------------------------------
      for (int i = 0; i < 11; i++) begin
         bus(vecs[i].daddr, vecs[i].dwdata, vecs[i].we);
         @(negedge clk);
         check($sformatf("vec%0d_sel", i), 32'(mmio_sel), 32'(vecs[i].exp_sel));
         check($sformatf("vec%0d_rdata", i), mmio_rdata, vecs[i].exp_rdata);
         step();
      end
      check("no_frame_from_vectors", 32'(rx_q.size()), 32'd0);

      // ---- single frame 0x55: latency, bit timing, busy -------------------
      clear_mon();
      bus(BASE, 32'h55, 4'b0001);
      step();                              // push edge N
      bus(STAT, 32'h0, 4'h0);
      @(negedge clk);
      check("f55_status_after_push", mmio_rdata, 32'h10);
      for (int k = 0; k <= 10 * CPB + 1; k++) begin
         if (k > 0) @(negedge clk);
         check($sformatf("f55_tx_k%0d", k), 32'(tx), 32'(frame_bit(8'h55, k)));
         check($sformatf("f55_busy_k%0d", k), 32'(mmio_rdata[0]),
               32'(k >= 1 && k <= 10 * CPB));
         step();
      end
      check("f55_frames", 32'(rx_q.size()), 32'd1);
      if (rx_q.size() > 0) check("f55_byte", 32'(rx_q[0]), 32'h155);

      // ---- fill FIFO, overflow, clear ovf ---------------------------------
      clear_mon();
      for (int i = 0; i < 9; i++) begin
         bus(BASE, 32'(i), 4'b0001);
         step();
      end
      bus(STAT, 32'h0, 4'h0);
      @(negedge clk);
      check("fill_status_full", mmio_rdata, 32'h83);
      step();
      bus(BASE, 32'h09, 4'b0001);
      step();
      bus(STAT, 32'h0, 4'h0);
      @(negedge clk);
      check("fill_status_ovf", mmio_rdata, 32'h8B);
      step();
      bus(STAT, 32'h8, 4'b0001);
      step();
      bus(STAT, 32'h0, 4'h0);
      @(negedge clk);
      check("fill_status_ovf_cleared", mmio_rdata, 32'h83);
      step();
      wait_idle(600);
      check("fill_frames", 32'(rx_q.size()), 32'd9);
      for (int i = 0; i < 9; i++) begin
         if (i < rx_q.size()) check($sformatf("fill_byte%0d", i), 32'(rx_q[i]), 32'h100 | 32'(i));
      end

      // ---- back-to-back frames --------------------------------------------
      clear_mon();
      bus(BASE, 32'hA5, 4'b0001);
      step();
      bus(BASE, 32'h3C, 4'b0001);
      step();
      wait_idle(300);
      check("b2b_frames", 32'(rx_q.size()), 32'd2);
      if (rx_q.size() >= 2) begin
         check("b2b_byte0", 32'(rx_q[0]), 32'h1A5);
         check("b2b_byte1", 32'(rx_q[1]), 32'h13C);
         check("b2b_gap", 32'(start_q[1] - start_q[0]), 32'd40);
         check("b2b_total", 32'(end_q[1] - start_q[0] + 1), 32'd80);
      end

      // ---- reset mid-frame, push coincident with reset --------------------
      clear_mon();
      bus(BASE, 32'h00, 4'b0001);
      step();                              // edge N: push 0x00
      bus(BASE, 32'h34, 4'b0001);
      step();                              // edge N+1: frame starts, push 0x34
      bus(STAT, 32'h0, 4'h0);
      repeat (10) step();                  // now just after edge N+11
      check("abort_midframe_tx", 32'(tx), 32'd0);
      reset = 1'b1;
      bus(BASE, 32'h77, 4'b0001);
      step();                              // edge N+12 sees reset
      reset = 1'b0;
      bus(STAT, 32'h0, 4'h0);
      @(negedge clk);
      check("abort_tx", 32'(tx), 32'd1);
      check("abort_status", mmio_rdata, 32'h04);
      zeros = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         @(negedge clk);
         if (tx !== 1'b1) zeros++;
      end
      check("abort_line_quiet", 32'(zeros), 32'd0);
      check("abort_frames", 32'(rx_q.size()), 32'd0);
      check("abort_status_end", mmio_rdata, 32'h04);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
